uart_packet_rx: RTL and testbench
=================================

# uart_packet_rx

Byte-stream packet parser on the receive side of the board's UART link. Consumes the UART receiver's byte strobe and decodes frames of the form SYNC, Destination, Source, Length, then Length data bytes. Presents the header fields, a per-byte payload stream and end-of-packet/error strobes to the register and control logic downstream. Sits between the UART receiver (opRxData/opRxValid) and the application core.

## Interface

Parameters:
- SYNC_BYTE, 8'h55, frame start marker.
- LOCAL_ADDRESS, 8'h00, destination address accepted by this node; 8'hFF is always accepted as broadcast.
- TIMEOUT_CYCLES, 50_000, maximum ipClk cycles between consecutive bytes inside a frame; counter width = $clog2(TIMEOUT_CYCLES+1).

Ports:
- ipClk  in  1  system clock.
- ipReset  in  1  synchronous, active-low reset.
- ipRxData  in  8  received byte from the UART receiver.
- ipRxValid  in  1  one-cycle strobe; ipRxData is valid while it is high.
- opDestination  out  8  destination byte of the current/last frame.
- opSource  out  8  source byte of the current/last frame.
- opLength  out  8  length byte of the current/last frame.
- opData  out  8  payload byte.
- opDataIndex  out  8  zero-based position of opData within the payload.
- opDataValid  out  1  one-cycle strobe qualifying opData/opDataIndex.
- opPacketDone  out  1  one-cycle strobe: accepted frame completed.
- opError  out  1  one-cycle strobe: frame aborted by inter-byte timeout.

## Operation

- States: IDLE, DEST, SRC, LEN, DATA.
- IDLE: byte == SYNC_BYTE -> DEST; any other byte is discarded and the state remains IDLE.
- DEST: capture opDestination; evaluate match = (byte == LOCAL_ADDRESS) || (byte == 8'hFF) into an internal flag -> SRC.
- SRC: capture opSource -> LEN.
- LEN: capture opLength; load remaining count = byte, index = 0. Byte == 0 -> IDLE, pulse opPacketDone if match. Otherwise -> DATA.
- DATA: each byte drives opData and opDataIndex = index, pulses opDataValid if match, then increments index and decrements remaining. When remaining hits 0 on this byte -> IDLE, with opPacketDone (if match) in the same cycle as the last opDataValid.
- Non-matching frame: every byte is still consumed and counted to stay in frame. opDataValid and opPacketDone are never asserted for that frame. Header outputs are still updated.
- A SYNC_BYTE value inside the header or payload is data, not a resync.
- Timeout: outside IDLE, the counter increments every cycle without ipRxValid and clears on ipRxValid. On reaching TIMEOUT_CYCLES: go to IDLE, pulse opError for one cycle, and do not pulse opPacketDone. The counter is held at 0 in IDLE.
- Timeout and ipRxValid in the same cycle: the byte wins, the counter clears, and there is no error.

## Timing

- All outputs are registered. Every output changes one cycle after the ipRxValid cycle carrying the causing byte.
- Reset (ipReset low at a rising edge): state IDLE, and all outputs 0, including opDestination, opSource, opLength, opData and opDataIndex. Timeout counter and match flag are cleared.
- Reset mid-frame abandons the frame with no opPacketDone and no opError. The next frame requires a fresh SYNC.
- Header outputs hold their value until overwritten by the next frame's corresponding byte. They remain readable after opPacketDone.
- opData/opDataIndex hold their value between strobes.
- Throughput: one byte accepted per ipRxValid with no minimum gap. A new frame may start on the byte immediately following the last data byte.
- Strobes are exactly one cycle wide; ipRxValid is never stalled.

## Test plan

- Nominal frame 55 00 AA 05 0F 0F 0F 0F 0F sent via the UART model -> opDestination=00, opSource=AA, opLength=05; five opDataValid pulses with opData=0F and index 0..4; opPacketDone coincides with index 4; opError stays 0.
- Leading garbage 12 34 then 55 FF 01 02 A1 B2 -> garbage ignored; broadcast accepted; data A1@0, B2@1; done on the second byte.
- Zero length 55 00 01 00 -> opPacketDone one cycle after the length byte; no opDataValid.
- Address mismatch 55 07 AA 02 11 22 followed immediately by 55 00 AA 01 33 -> first frame produces no data or done, header shows 07; second frame produces 33@0 and done.
- Timeout with TIMEOUT_CYCLES=100: 55 00 AA 03 11, then silence -> one opDataValid, opError pulse exactly 100 cycles after the last strobe, no done; a following full frame decodes normally.
- Reset low for 1 cycle after 55 00 AA 04 -> all outputs 0; subsequent 66 55 00 AA 01 77 yields 77@0 and done.

Source files
------------

// File: rtl/uart_packet_rx.sv
// Byte-stream frame parser behind the UART receiver: SYNC, destination, source,
// length, then length payload bytes, with an inter-byte timeout inside a frame.
module uart_packet_rx #(
    parameter logic [7:0]  SYNC_BYTE      = 8'h55,
    parameter logic [7:0]  LOCAL_ADDRESS  = 8'h00,
    parameter int unsigned TIMEOUT_CYCLES = 50_000
) (
    input  logic       ipClk,
    input  logic       ipReset,
    input  logic [7:0] ipRxData,
    input  logic       ipRxValid,
    output logic [7:0] opDestination,
    output logic [7:0] opSource,
    output logic [7:0] opLength,
    output logic [7:0] opData,
    output logic [7:0] opDataIndex,
    output logic       opDataValid,
    output logic       opPacketDone,
    output logic       opError
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        DEST = 3'd1,
        SRC  = 3'd2,
        LEN  = 3'd3,
        DATA = 3'd4
    } state_t;

    state_t        state;
    logic [CW-1:0] gap_count;
    logic          match;
    logic [7:0]    remaining;
    logic [7:0]    index;

    always_ff @(posedge ipClk) begin
        if (!ipReset) begin
            state         <= IDLE;
            gap_count     <= '0;
            match         <= 1'b0;
            remaining     <= 8'd0;
            index         <= 8'd0;
            opDestination <= 8'd0;
            opSource      <= 8'd0;
            opLength      <= 8'd0;
            opData        <= 8'd0;
            opDataIndex   <= 8'd0;
            opDataValid   <= 1'b0;
            opPacketDone  <= 1'b0;
            opError       <= 1'b0;
        end else begin
            opDataValid  <= 1'b0;
            opPacketDone <= 1'b0;
            opError      <= 1'b0;

            if (state == IDLE) begin
                gap_count <= '0;
                if (ipRxValid && (ipRxData == SYNC_BYTE)) begin
                    state <= DEST;
                end
            end else if (ipRxValid) begin
                // A byte always beats a timeout landing in the same cycle.
                gap_count <= '0;
                case (state)
                    DEST: begin
                        opDestination <= ipRxData;
                        match         <= (ipRxData == LOCAL_ADDRESS) || (ipRxData == 8'hFF);
                        state         <= SRC;
                    end
                    SRC: begin
                        opSource <= ipRxData;
                        state    <= LEN;
                    end
                    LEN: begin
                        opLength  <= ipRxData;
                        remaining <= ipRxData;
                        index     <= 8'd0;
                        if (ipRxData == 8'd0) begin
                            opPacketDone <= match;
                            state        <= IDLE;
                        end else begin
                            state <= DATA;
                        end
                    end
                    DATA: begin
                        // Non-matching frames are still walked byte by byte to stay aligned.
                        opData      <= ipRxData;
                        opDataIndex <= index;
                        opDataValid <= match;
                        index       <= index + 8'd1;
                        remaining   <= remaining - 8'd1;
                        if (remaining == 8'd1) begin
                            opPacketDone <= match;
                            state        <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (gap_count == TIMEOUT_LAST) begin
                gap_count <= '0;
                opError   <= 1'b1;
                state     <= IDLE;
            end else begin
                gap_count <= gap_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_packet_rx.sv
// Bench for uart_packet_rx: directed and random byte streams, checked against a
// frame-level model that turns the recorded stream into expected output events.
module tb_uart_packet_rx;

    localparam int         T     = 100;
    localparam logic [7:0] SYNC  = 8'h55;
    localparam logic [7:0] LOCAL = 8'h00;
    localparam int         W     = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'd0;
    logic       rx_valid = 1'b0;
    logic [7:0] destination, source, length, data, data_index;
    logic       data_valid, packet_done, error;

    uart_packet_rx #(
        .SYNC_BYTE(SYNC),
        .LOCAL_ADDRESS(LOCAL),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .ipClk(clk),
        .ipReset(rst_n),
        .ipRxData(rx_data),
        .ipRxValid(rx_valid),
        .opDestination(destination),
        .opSource(source),
        .opLength(length),
        .opData(data),
        .opDataIndex(data_index),
        .opDataValid(data_valid),
        .opPacketDone(packet_done),
        .opError(error)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] act_q[$];
    logic [7:0]   sb[$];
    int           sc[$];
    logic [7:0]   m_dest = 8'd0, m_src = 8'd0, m_len = 8'd0, m_data = 8'd0, m_idx = 8'd0;

    task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Event record: kind (0 data, 1 done, 2 error), cycle, data, index, header fields.
    function automatic logic [W-1:0] ev(input int kind, input int c, input logic [7:0] d,
                                        input logic [7:0] i, input logic [7:0] h0,
                                        input logic [7:0] h1, input logic [7:0] h2);
        logic [1:0]  k;
        logic [21:0] cc;
        k  = kind[1:0];
        cc = c[21:0];
        return {k, cc, d, i, h0, h1, h2};
    endfunction

    always @(negedge clk) begin
        if (data_valid === 1'b1)
            act_q.push_back(ev(0, cyc, data, data_index, destination, source, length));
        if (packet_done === 1'b1)
            act_q.push_back(ev(1, cyc, 8'd0, 8'd0, destination, source, length));
        if (error === 1'b1)
            act_q.push_back(ev(2, cyc, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0));
    end

    // Reference model: walks the recorded (byte, cycle) stream frame by frame.
    // A gap of more than T cycles between bytes of one frame aborts it at last+T.
    function automatic void process_segment(input int end_c);
        int n, i, k, pos, idx;
        logic m;
        logic [7:0] d, s, l, b;
        n = sb.size();
        i = 0;
        while (i < n) begin
            if (sb[i] != SYNC) begin
                i++;
                continue;
            end
            k = i + 1; m = 1'b0; d = 8'd0; s = 8'd0; l = 8'd0;
            while (1) begin
                if (k >= n) begin
                    if (sc[k-1] + T < end_c)
                        exp_q.push_back(ev(2, sc[k-1] + T, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0));
                    i = n;
                    break;
                end
                if (sc[k] - sc[k-1] > T) begin
                    exp_q.push_back(ev(2, sc[k-1] + T, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0));
                    i = k;
                    break;
                end
                b = sb[k];
                pos = k - i;
                if (pos == 1) begin
                    d = b; m_dest = b;
                    m = (b == LOCAL) || (b == 8'hFF);
                end else if (pos == 2) begin
                    s = b; m_src = b;
                end else if (pos == 3) begin
                    l = b; m_len = b;
                    if (l == 8'd0) begin
                        if (m) exp_q.push_back(ev(1, sc[k], 8'd0, 8'd0, d, s, l));
                        i = k + 1;
                        break;
                    end
                end else begin
                    idx = pos - 4;
                    m_data = b;
                    m_idx = idx[7:0];
                    if (m) exp_q.push_back(ev(0, sc[k], b, idx[7:0], d, s, l));
                    if (idx == int'(l) - 1) begin
                        if (m) exp_q.push_back(ev(1, sc[k], 8'd0, 8'd0, d, s, l));
                        i = k + 1;
                        break;
                    end
                end
                k++;
            end
        end
        sb.delete();
        sc.delete();
    endfunction

    task automatic compare_events(input string tag);
        int n;
        check({tag, "_event_count"}, W'(act_q.size()), W'(exp_q.size()));
        n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, "_event"}, act_q[i], exp_q[i]);
        act_q.delete();
        exp_q.delete();
    endtask

    // Driver tasks
    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(posedge clk);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back(b);
        sc.push_back(cyc);
        rx_valid = 1'b0;
    endtask

    task automatic send_q(input logic [7:0] q[$]);
        foreach (q[i]) send_byte(q[i], 0);
    endtask

    task automatic check_outputs(input string tag, input logic [7:0] d, input logic [7:0] s,
                                 input logic [7:0] l, input logic [7:0] pd, input logic [7:0] pi);
        check({tag, "_destination"}, W'(destination), W'(d));
        check({tag, "_source"}, W'(source), W'(s));
        check({tag, "_length"}, W'(length), W'(l));
        check({tag, "_data"}, W'(data), W'(pd));
        check({tag, "_index"}, W'(data_index), W'(pi));
    endtask

    task automatic checkpoint(input string tag);
        repeat (T + 5) @(posedge clk);
        #1;
        process_segment(cyc);
        compare_events(tag);
        check_outputs(tag, m_dest, m_src, m_len, m_data, m_idx);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        process_segment(cyc);
        rst_n = 1'b1;
        compare_events(tag);
        m_dest = 8'd0; m_src = 8'd0; m_len = 8'd0; m_data = 8'd0; m_idx = 8'd0;
        check_outputs(tag, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        check({tag, "_strobes"}, W'({data_valid, packet_done, error}), W'(3'b000));
    endtask

    function automatic int rand_gap();
        int r;
        r = $urandom_range(0, 49);
        if (r == 0) return T - 1;
        if (r == 1) return T;
        if (r < 10) return $urandom_range(1, 4);
        return 0;
    endfunction

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q[$];
        logic [7:0] addr;
        int len;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset", 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        check("reset_strobes", W'({data_valid, packet_done, error}), W'(3'b000));
        rst_n = 1'b1;

        q = '{8'h55, 8'h00, 8'hAA, 8'h05, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F};
        send_q(q);
        checkpoint("nominal");

        q = '{8'h12, 8'h34, 8'h55, 8'hFF, 8'h01, 8'h02, 8'hA1, 8'hB2};
        send_q(q);
        checkpoint("broadcast");

        q = '{8'h55, 8'h00, 8'h01, 8'h00};
        send_q(q);
        checkpoint("zero_len");

        q = '{8'h55, 8'h07, 8'hAA, 8'h02, 8'h11, 8'h22, 8'h55, 8'h00, 8'hAA, 8'h01, 8'h33};
        send_q(q);
        checkpoint("mismatch");

        q = '{8'h55, 8'h00, 8'hAA, 8'h03, 8'h11};
        send_q(q);
        checkpoint("timeout");
        q = '{8'h55, 8'h00, 8'hAA, 8'h02, 8'h55, 8'h66};
        send_q(q);
        checkpoint("after_timeout");

        // Gap boundaries: T-1 idle cycles survives, T idle cycles times out.
        send_byte(8'h55, 0); send_byte(8'hFF, 0); send_byte(8'h03, 0); send_byte(8'h02, 0);
        send_byte(8'hC1, T - 1); send_byte(8'hC2, 0);
        send_byte(8'h55, 0); send_byte(8'h00, 0); send_byte(8'h04, T);
        send_byte(8'h55, 0); send_byte(8'h00, 0); send_byte(8'h09, 0); send_byte(8'h01, 0);
        send_byte(8'hD4, 0);
        checkpoint("gap_edge");

        q = '{8'h55, 8'h00, 8'hAA, 8'h04};
        send_q(q);
        do_reset("mid_reset");
        q = '{8'h66, 8'h55, 8'h00, 8'hAA, 8'h01, 8'h77};
        send_q(q);
        checkpoint("after_reset");

        // Random frames with occasional garbage and long gaps
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 3) == 0) send_byte(8'($urandom_range(0, 255)), rand_gap());
            case ($urandom_range(0, 3))
                0:       addr = LOCAL;
                1:       addr = 8'hFF;
                2:       addr = 8'h07;
                default: addr = 8'($urandom_range(0, 255));
            endcase
            len = $urandom_range(0, 6);
            send_byte(SYNC, rand_gap());
            send_byte(addr, rand_gap());
            send_byte(8'($urandom_range(0, 255)), rand_gap());
            send_byte(8'(len), rand_gap());
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 7) == 0) send_byte(SYNC, rand_gap());
                else send_byte(8'($urandom_range(0, 255)), rand_gap());
            end
            if (f % 10 == 9) checkpoint("random");
            if (f == 24) do_reset("random_reset");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
